// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and FSM encoding for alu_arbiter
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF   = 4;
  localparam int SHAMT_WIDTH    = 5;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant pointer
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_ptr
);

  logic       r_ptr;
  logic [1:0] w_gnt;

  // r_ptr names the requester granted last; it loses a tie next time
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        w_gnt = r_ptr ? 2'b01 : 2'b10;
      end else if (i_req0) begin
        w_gnt = 2'b01;
      end else if (i_req1) begin
        w_gnt = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b1;
    end else if (w_gnt != 2'b00) begin
      r_ptr <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;
  assign o_ptr = r_ptr;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [OP_WIDTH-1:0]    req0_op,
  input  logic [DATA_WIDTH-1:0]  req0_a,
  input  logic [DATA_WIDTH-1:0]  req0_b,
  input  logic [SHAMT_WIDTH-1:0] req0_shamt,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [OP_WIDTH-1:0]    req1_op,
  input  logic [DATA_WIDTH-1:0]  req1_a,
  input  logic [DATA_WIDTH-1:0]  req1_b,
  input  logic [SHAMT_WIDTH-1:0] req1_shamt,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [DATA_WIDTH-1:0]  rsp0_result,
  output logic                   rsp0_zero,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [DATA_WIDTH-1:0]  rsp1_result,
  output logic                   rsp1_zero,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [SHAMT_WIDTH-1:0] alu_shamt,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic                   alu_zero
);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             w_gnt;
  logic                   w_owner;
  logic                   w_arb_en;
  logic                   w_accept;
  logic                   w_rsp_done;
  logic [OP_WIDTH-1:0]    r_op;
  logic [DATA_WIDTH-1:0]  r_a;
  logic [DATA_WIDTH-1:0]  r_b;
  logic [SHAMT_WIDTH-1:0] r_shamt;
  logic [DATA_WIDTH-1:0]  r_res0;
  logic [DATA_WIDTH-1:0]  r_res1;
  logic                   r_zero0;
  logic                   r_zero1;

  // After an accept the pointer holds the in-flight owner, so it doubles as the response select
  assign w_arb_en = (r_state == ST_IDLE) && !reset;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .i_req0 (req0_valid),
    .i_req1 (req1_valid),
    .i_en   (w_arb_en),
    .o_gnt  (w_gnt),
    .o_ptr  (w_owner)
  );

  assign w_accept   = |w_gnt;
  assign w_rsp_done = (r_state == ST_RESP) && (w_owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP:  if (w_rsp_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_gnt[0];
    req1_ready = w_gnt[1];
    rsp0_valid = !reset && (r_state == ST_RESP) && !w_owner;
    rsp1_valid = !reset && (r_state == ST_RESP) && w_owner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_shamt <= '0;
    end else if (w_gnt[1]) begin
      r_op    <= req1_op;
      r_a     <= req1_a;
      r_b     <= req1_b;
      r_shamt <= req1_shamt;
    end else if (w_gnt[0]) begin
      r_op    <= req0_op;
      r_a     <= req0_a;
      r_b     <= req0_b;
      r_shamt <= req0_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res0  <= '0;
      r_res1  <= '0;
      r_zero0 <= 1'b0;
      r_zero1 <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      if (w_owner) begin
        r_res1  <= alu_result;
        r_zero1 <= alu_zero;
      end else begin
        r_res0  <= alu_result;
        r_zero0 <= alu_zero;
      end
    end
  end

  assign alu_op      = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_shamt   = r_shamt;
  assign rsp0_result = r_res0;
  assign rsp0_zero   = r_zero0;
  assign rsp1_result = r_res1;
  assign rsp1_zero   = r_zero1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level model
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]    req0_shamt = '0, req1_shamt = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [4:0]    alu_shamt;
  logic          alu_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [4:0] sh);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~(a | b);
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_op, alu_a, alu_b, alu_shamt);
    alu_zero   = (alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one operation in flight, response due two cycles after accept
  bit            m_on = 0, m_busy = 0, m_last = 1;
  int            m_owner = 0, m_age = 0;
  logic [DW-1:0] m_res = '0;
  bit            f_acc0, f_acc1, f_rsp0, f_rsp1;

  always @(negedge clk) begin
    bit e_v0, e_v1;
    int win;
    f_acc0 = ((req0_valid & req0_ready) === 1'b1);
    f_acc1 = ((req1_valid & req1_ready) === 1'b1);
    f_rsp0 = ((rsp0_valid & rsp0_ready) === 1'b1);
    f_rsp1 = ((rsp1_valid & rsp1_ready) === 1'b1);
    if (reset) begin
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      m_on = 1; m_busy = 0; m_last = 1;
    end else if (m_on) begin
      if (m_busy) m_age++;
      win = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) win = m_last ? 0 : 1;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end
      e_v0 = m_busy && m_owner == 0 && m_age >= 2;
      e_v1 = m_busy && m_owner == 1 && m_age >= 2;
      check("req0_ready", req0_ready, (win == 0));
      check("req1_ready", req1_ready, (win == 1));
      check("rsp0_valid", rsp0_valid, e_v0);
      check("rsp1_valid", rsp1_valid, e_v1);
      if (e_v0) begin
        check("rsp0_result", rsp0_result, m_res);
        check("rsp0_zero", rsp0_zero, (m_res == '0));
      end
      if (e_v1) begin
        check("rsp1_result", rsp1_result, m_res);
        check("rsp1_zero", rsp1_zero, (m_res == '0));
      end
      if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
        m_busy = 0;
      end else if (win >= 0) begin
        m_busy = 1; m_owner = win; m_age = 0; m_last = (win == 1);
        m_res = (win == 0) ? alu_fn(req0_op, req0_a, req0_b, req0_shamt)
                           : alu_fn(req1_op, req1_a, req1_b, req1_shamt);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic obs();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(); reset = 1; req0_valid = 0; req1_valid = 0;
    cyc(); cyc(); reset = 0;
  endtask

  // kind 0 waits for reqN_ready, kind 1 for rspN_valid; returns at an observe point
  task automatic wait_sig(input int n, input int kind, output bit ok);
    logic s;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      obs();
      if (kind == 0) s = n ? req1_ready : req0_ready;
      else           s = n ? rsp1_valid : rsp0_valid;
      if (s === 1'b1) begin ok = 1; return; end
      cyc();
    end
    check($sformatf("timeout_n%0d_k%0d", n, kind), 0, 1);
  endtask

  task automatic drive(input int n, input logic v, input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] sh);
    if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh; end
    else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh; end
  endtask

  task automatic single(input int n, input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [4:0] sh, output logic [DW-1:0] res, output logic z);
    bit ok;
    drive(n, 1, op, a, b, sh);
    wait_sig(n, 0, ok);
    cyc();
    if (n == 0) req0_valid = 0; else req1_valid = 0;
    wait_sig(n, 1, ok);
    res = n ? rsp1_result : rsp0_result;
    z   = n ? rsp1_zero : rsp0_zero;
    cyc();
  endtask

  task automatic rnd_drive(input int n);
    logic [DW-1:0] a, b;
    a = $urandom;
    b = ($urandom % 4 == 0) ? a : $urandom;
    drive(n, 1, 4'($urandom_range(0, 8)), a, b, 5'($urandom % 32));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] r, held;
    logic z;
    bit ok;
    int gq[$];
    int n_acc, n_r0, n_r1;

    // single ADD with exact latency
    do_reset();
    drive(0, 1, 4'd3, 32'd5, 32'd7, 5'd0);
    obs(); check("add_accept", req0_ready, 1);
    cyc(); req0_valid = 0;
    obs(); check("add_t1_valid", rsp0_valid, 0);
    cyc();
    obs(); check("add_t2_valid", rsp0_valid, 1);
    check("add_result", rsp0_result, 12);
    check("add_zero", rsp0_zero, 0);
    cyc();

    // contention straight after reset: requester 0 first
    do_reset();
    drive(0, 1, 4'd4, 32'd9, 32'd9, 5'd0);
    drive(1, 1, 4'd1, 32'hF0, 32'h0F, 5'd0);
    obs(); check("cont_r0_ready", req0_ready, 1); check("cont_r1_ready", req1_ready, 0);
    cyc(); req0_valid = 0;
    wait_sig(0, 1, ok);
    check("cont_sub_result", rsp0_result, 0); check("cont_sub_zero", rsp0_zero, 1);
    cyc();
    wait_sig(1, 0, ok);
    cyc(); req1_valid = 0;
    wait_sig(1, 1, ok);
    check("cont_or_result", rsp1_result, 32'hFF); check("cont_or_zero", rsp1_zero, 0);
    cyc();

    // back-pressure on rsp1 while req0 waits
    rsp1_ready = 0;
    drive(1, 1, 4'd3, 32'h1234, 32'h1, 5'd0);
    wait_sig(1, 0, ok);
    cyc(); req1_valid = 0;
    drive(0, 1, 4'd0, 32'hFF00, 32'h0FF0, 5'd0);
    wait_sig(1, 1, ok);
    held = rsp1_result;
    check("bp_held_value", held, 32'h1235);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp1_stable", rsp1_result, held);
      check("bp_req0_ready", req0_ready, 0);
      cyc(); obs();
    end
    cyc(); rsp1_ready = 1;
    obs(); check("bp_release_req0_ready", req0_ready, 0);
    cyc();
    obs(); check("bp_resume_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    wait_sig(0, 1, ok);
    check("bp_and_result", rsp0_result, 32'h0F00);
    cyc();

    // shifts at the extreme amount
    single(1, 4'd5, 32'd1, 32'd0, 5'd31, r, z);
    check("sll_result", r, 32'h8000_0000);
    single(1, 4'd6, 32'h8000_0000, 32'd0, 5'd31, r, z);
    check("srl_result", r, 32'd1);
    single(0, 4'd9, 32'd3, 32'd4, 5'd0, r, z);
    check("undef_result", r, 0); check("undef_zero", z, 1);

    // reset while a response is pending
    rsp0_ready = 0;
    drive(0, 1, 4'd3, 32'd1, 32'd2, 5'd0);
    wait_sig(0, 0, ok);
    cyc(); req0_valid = 0;
    wait_sig(0, 1, ok);
    cyc(); reset = 1;
    obs(); check("rr_valid_during_reset", rsp0_valid, 0);
    cyc(); reset = 0; rsp0_ready = 1;
    obs();
    check("rr_rsp0_valid", rsp0_valid, 0);
    check("rr_rsp0_result", rsp0_result, 0);
    check("rr_rsp0_zero", rsp0_zero, 0);
    check("rr_alu_a", alu_a, 0);
    check("rr_alu_op", alu_op, 0);
    cyc();
    drive(0, 1, 4'd0, 32'hF, 32'h3, 5'd0);
    drive(1, 1, 4'd2, 32'h0, 32'h0, 5'd0);
    obs(); check("rr_grant_r0", req0_ready, 1); check("rr_grant_r1", req1_ready, 0);
    cyc(); req0_valid = 0;
    wait_sig(0, 1, ok);
    check("rr_and_result", rsp0_result, 3);
    cyc();
    wait_sig(1, 0, ok);
    cyc(); req1_valid = 0;
    wait_sig(1, 1, ok);
    check("rr_nor_result", rsp1_result, 32'hFFFF_FFFF);
    cyc();

    // fairness: both requesters permanently busy for 20 operations
    do_reset();
    rnd_drive(0); rnd_drive(1);
    n_acc = 0; n_r0 = 0; n_r1 = 0;
    for (int i = 0; i < 300 && (n_r0 + n_r1) < 20; i++) begin
      obs();
      if (f_acc0) begin gq.push_back(0); n_acc++; end
      if (f_acc1) begin gq.push_back(1); n_acc++; end
      if (f_rsp0) n_r0++;
      if (f_rsp1) n_r1++;
      cyc();
      if (f_acc0) begin if (n_acc < 20) rnd_drive(0); else req0_valid = 0; end
      if (f_acc1) begin if (n_acc < 20) rnd_drive(1); else req1_valid = 0; end
    end
    req0_valid = 0; req1_valid = 0;
    check("fair_accepts", gq.size(), 20);
    check("fair_resp0", n_r0, 10);
    check("fair_resp1", n_r1, 10);
    for (int i = 0; i < gq.size(); i++) check($sformatf("fair_grant_%0d", i), gq[i], i % 2);

    // random traffic with random back-pressure and undefined opcodes
    for (int i = 0; i < 600; i++) begin
      obs();
      cyc();
      if (!req0_valid || f_acc0) begin rnd_drive(0); req0_valid = ($urandom % 3) != 0; end
      if (!req1_valid || f_acc1) begin rnd_drive(1); req1_valid = ($urandom % 3) != 0; end
      rsp0_ready = ($urandom % 4) != 0;
      rsp1_ready = ($urandom % 4) != 0;
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 8; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
